// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: scoreboard-driven bypass selects and load-use stall for the RISC-V decode stage.
// Define HAZARD_PERF_CNT_EN to add the 32-bit stall_count output.
module hazard_forward_unit #(
    parameter int no_of_registers = 32,
    parameter int DEPTH = 3,
    localparam int RW = $clog2(no_of_registers),
    localparam int SELW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [6:0]      from_IMEM,
    input  logic [RW-1:0]   rs1_next,
    input  logic [RW-1:0]   rs2_next,
    input  logic [RW-1:0]   rd_next,
    input  logic            flush,
    output logic            stall,
    output logic [SELW-1:0] fwd_rs1,
    output logic [SELW-1:0] fwd_rs2
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]     stall_count
`endif
);
    logic is_r, is_i, is_ld, is_s, is_b, is_jal, is_jalr, is_lui, is_auipc;
    logic wr, use1, use2, ld;
    logic [DEPTH:1] e_v, e_ld, m1, m2;
    logic [RW-1:0] e_rd [1:DEPTH];
    logic [SELW-1:0] f1, f2;
    assign is_r     = from_IMEM == 7'b0110011;
    assign is_i     = from_IMEM == 7'b0010011;
    assign is_ld    = from_IMEM == 7'b0000011;
    assign is_s     = from_IMEM == 7'b0100011;
    assign is_b     = from_IMEM == 7'b1100011;
    assign is_jal   = from_IMEM == 7'b1101111;
    assign is_jalr  = from_IMEM == 7'b1100111;
    assign is_lui   = from_IMEM == 7'b0110111;
    assign is_auipc = from_IMEM == 7'b0010111;
    assign wr   = in_valid & (is_r | is_i | is_ld | is_jal | is_jalr | is_lui | is_auipc) & (rd_next != '0);
    assign use1 = in_valid & (is_r | is_i | is_ld | is_s | is_b | is_jalr);
    assign use2 = in_valid & (is_r | is_s | is_b);
    assign ld   = in_valid & is_ld;
    always_ff @(posedge clk) begin
        if (rst) begin
            e_v  <= '0;
            e_ld <= '0;
            for (int k = 1; k <= DEPTH; k++) e_rd[k] <= '0;
        end else begin
            for (int k = DEPTH; k > 1; k--) begin
                e_v[k]  <= e_v[k-1] & ~flush;
                e_ld[k] <= e_ld[k-1];
                e_rd[k] <= e_rd[k-1];
            end
            // a stalled decode instruction is re-presented, so EX gets a bubble
            e_v[1]  <= wr & ~flush & ~stall;
            e_ld[1] <= ld & ~flush & ~stall;
            e_rd[1] <= rd_next;
        end
    end
    always_comb begin
        m1 = '0;
        m2 = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            m1[k] = use1 & e_v[k] & (e_rd[k] == rs1_next) & (rs1_next != '0);
            m2[k] = use2 & e_v[k] & (e_rd[k] == rs2_next) & (rs2_next != '0);
        end
    end
    // scan farthest to nearest so the nearest producer overwrites
    always_comb begin
        f1 = '0;
        f2 = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            f1 = m1[k] ? SELW'(k) : f1;
            f2 = m2[k] ? SELW'(k) : f2;
        end
    end
    assign stall   = (m1[1] | m2[1]) & e_ld[1];
    assign fwd_rs1 = stall ? '0 : f1;
    assign fwd_rs2 = stall ? '0 : f2;
`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) stall_count <= rst ? '0 : stall_count + 32'(stall);
`endif
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised successor to the combinational forwarding comparator, for the RISC-V pipeline.
- Owns an internal shift-register scoreboard of in-flight destination registers, DEPTH stages deep.
- Decodes the decode-stage opcode to determine rd-write, rs1-use and rs2-use.
- Produces encoded per-source bypass selects and a load-use stall, with bubble insertion and flush.
- Sits between instruction decode and the execute-stage operand muxes.

Parameters:
- no_of_registers, 32: architectural register count; index width RW = $clog2(no_of_registers).
- DEPTH, 3: number of tracked producer stages after decode (EX, MEM, WB by default). Legal range 2..7.
- SELW, $clog2(DEPTH+1): width of the forward-select outputs. Derived; not to be overridden.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: decode-stage instruction valid.
- from_IMEM, input, 7: decode-stage opcode[6:0].
- rs1_next, input, RW: decode-stage rs1 index.
- rs2_next, input, RW: decode-stage rs2 index.
- rd_next, input, RW: decode-stage rd index.
- flush, input, 1: kill all in-flight entries (branch/jump redirect).
- stall, output, 1: hold PC and IF/ID; insert a bubble into EX.
- fwd_rs1, output, SELW: 0 = register file; k = bypass from stage k (1 = nearest).
- fwd_rs2, output, SELW: same encoding as fwd_rs1, for rs2.

Behaviour:
- Opcode decode (only when in_valid=1; otherwise nothing is written and no source is used):
  - wr = opcode in {0110011, 0010011, 0000011, 1101111, 1100111, 0110111, 0010111} and rd_next != 0.
  - use1 = opcode in {0110011, 0010011, 0000011, 0100011, 1100011, 1100111}.
  - use2 = opcode in {0110011, 0100011, 1100011}.
  - ld = opcode == 0000011.
  - Store (0100011) and branch (1100011) never write rd.
- Scoreboard: entries e[1..DEPTH], each {v, rd, ld}. rst=1 clears all v, rd and ld to 0.
- Each clock edge, e[k+1] <= e[k] for k = 1..DEPTH-1; e[DEPTH] retires.
- e[1] load value, in priority order:
  - flush=1: every entry, including e[1], loads v=0. Flush overrides stall.
  - else stall=1: e[1] loads a bubble (v=0); the decode instruction is not captured and is re-presented next cycle.
  - else: e[1] <= {wr, rd_next, ld}.
- Match (combinational): m1[k] = use1 & e[k].v & (e[k].rd == rs1_next) & (rs1_next != 0). m2[k] is the same for rs2.
- Stall: stall = (m1[1] | m2[1]) & e[1].ld. Load-use hazard only; a load in stage 2 or later is forwarded, never stalled.
- Forward select: fwd_rsX = smallest k with mX[k]=1, else 0. The nearest producer wins when several stages match.
- While stall=1, both fwd outputs are forced to 0.
- Latency: outputs are combinational on the current inputs plus the registered scoreboard; a producer becomes visible one edge after acceptance.
- After rst, stall=0 and fwd_rs1 = fwd_rs2 = 0 until a writer is accepted.
- Reset mid-operation clears everything at the edge. rst has priority over flush.
- x0 is never forwarded or stalled on, in either the source or destination role.
- Flush in the same cycle as a stall: the stall is still asserted that cycle; all entries are invalid next cycle, so the stall clears.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds output stall_count, 32 bits: counts cycles with stall=1.
  - Cleared by rst; wraps at 2^32-1 -> 0.
  - Not cleared by flush.
- Undefined: no port and no counter; all other behaviour is identical.

Test Plan:
1. Writer then reader: accept add x5 (0110011, rd=5), then present sub rs1=5, rs2=6 -> fwd_rs1=1, fwd_rs2=0, stall=0. One idle cycle later -> fwd_rs1=2. After DEPTH+1 cycles -> 0.
2. Load-use: accept lw x7 (0000011), then present add rs2=7 -> stall=1 for exactly 1 cycle, fwd forced to 0. Next cycle same instruction -> stall=0, fwd_rs2=2. (Optional counter: stall_count=1.)
3. Priority: accept addi x3, addi x3, then add rs1=3 -> fwd_rs1=1, not 2. Store sw rs2=3 after a writer -> fwd_rs2=1. A store (0100011, rd field 3) never creates a match.
4. x0 and non-users: accept addi rd=0, then add rs1=0 -> fwd_rs1=0. Then lui (0110111) with rs1 field = matching rd -> fwd_rs1=0 (rs1 not used).
5. Flush: accept lw x9, then assert flush while add rs1=9 is presented -> stall=1 that cycle. Next cycle all entries invalid; same add -> stall=0, fwd_rs1=0.
6. Reset mid-stream: three writers in flight, assert rst one cycle -> next cycle all outputs 0 for any rs1/rs2. Run with DEPTH=5 -> fwd values 1..5 reached, and SELW=3.
